// File: rtl/reconf_fir_pkg.sv
// Shared sizes, FSM state type and output saturation helper for reconf_fir_filter.
// Output saturation is selected in the top with the FIR_OUT_SAT_EN macro.
package reconf_fir_pkg;

    localparam int NUM_TAPS = 40;
    localparam int COEF_W   = 16;
    localparam int IN_W     = 3;
    localparam int OUT_W    = 16;
    localparam int ACC_W    = 25;
    localparam int IDX_W    = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_RUN    = 2'd2
    } fir_state_e;

    // Clamp a full-width accumulator sum into the signed output range.
    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] max_v;
        logic signed [ACC_W-1:0] min_v;
        max_v = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        min_v = ~max_v;
        if (v > max_v) begin
            sat_out = max_v[OUT_W-1:0];
        end else if (v < min_v) begin
            sat_out = min_v[OUT_W-1:0];
        end else begin
            sat_out = v[OUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/reconf_fir_filter_regfile.sv
// 40 x 16-bit coefficient bank for reconf_fir_filter: one write port, all
// entries visible in parallel, asynchronous clear.
module fir_coeff_regfile
    import reconf_fir_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_en,
    input  logic [IDX_W-1:0]                   wr_idx,
    input  logic [COEF_W-1:0]                  wr_data,
    output logic [NUM_TAPS-1:0][COEF_W-1:0]    coef_o
);

    logic [NUM_TAPS-1:0][COEF_W-1:0] coef_q;
    logic [NUM_TAPS-1:0][COEF_W-1:0] coef_d;

    always_comb begin
        coef_d = coef_q;
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (wr_en && (wr_idx == IDX_W'(k))) begin
                coef_d[k] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_q <= '0;
        end else begin
            coef_q <= coef_d;
        end
    end

    assign coef_o = coef_q;

endmodule

// File: rtl/reconf_fir_filter.sv
// Reconfigurable 40-tap transposed-form FIR with load/run FSM and strobe edge detect.
// Define FIR_OUT_SAT_EN to saturate the output instead of wrapping to 16 bits.
module reconf_fir_filter
    import reconf_fir_pkg::*;
(
    input  logic        iClk_12M,
    input  logic        iRsn,
    input  logic        iEnSample_300k,
    input  logic        iCoeffiUpdateFlag,
    input  logic        iCsnRam,
    input  logic        iWrnRam,
    input  logic [3:0]  iAddrRam,
    input  logic [15:0] iWrDtRam,
    input  logic [5:0]  iNumOfCoeff,
    input  logic [2:0]  iFirIn,
    output logic [15:0] oFirOut
);

    fir_state_e state_q, state_d;
    logic       en_prev_q, en_prev_d;
    logic signed [OUT_W-1:0] out_q, out_d;
    logic signed [ACC_W-1:0] z_q [1:NUM_TAPS-1];
    logic signed [ACC_W-1:0] z_d [1:NUM_TAPS-1];

    logic [NUM_TAPS-1:0][COEF_W-1:0] coef;
    logic signed [ACC_W-1:0] prod [NUM_TAPS];
    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] acc0;
    logic signed [OUT_W-1:0] out_mapped;
    logic coef_wr_en;
    logic enter_update;
    logic step;
    logic unused_addr;

    assign unused_addr = ^iAddrRam;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (iCoeffiUpdateFlag)  state_d = ST_UPDATE;
            ST_UPDATE: if (!iCoeffiUpdateFlag) state_d = ST_RUN;
            ST_RUN:    if (iCoeffiUpdateFlag)  state_d = ST_UPDATE;
            default:                           state_d = ST_IDLE;
        endcase
        enter_update = (state_q != ST_UPDATE) && (state_d == ST_UPDATE);
        // The flag term lets a write land on the same edge the flag rises.
        coef_wr_en = ((state_q == ST_UPDATE) || iCoeffiUpdateFlag) && !iCsnRam && !iWrnRam
                     && (iNumOfCoeff < IDX_W'(NUM_TAPS));
        en_prev_d  = iEnSample_300k;
        step       = iEnSample_300k && !en_prev_q && (state_q == ST_RUN);
    end

    fir_coeff_regfile u_regfile (
        .clk     (iClk_12M),
        .rst_n   (iRsn),
        .wr_en   (coef_wr_en),
        .wr_idx  (iNumOfCoeff),
        .wr_data (iWrDtRam),
        .coef_o  (coef)
    );

    always_comb begin
        x_ext = ACC_W'($signed(iFirIn));
        for (int k = 0; k < NUM_TAPS; k++) begin
            prod[k] = ACC_W'($signed(coef[k])) * x_ext;
        end
        acc0 = prod[0] + z_q[1];
`ifdef FIR_OUT_SAT_EN
        out_mapped = sat_out(acc0);
`else
        out_mapped = acc0[OUT_W-1:0];
`endif
        z_d   = z_q;
        out_d = out_q;
        // Clearing on UPDATE entry wins over a coincident strobe.
        if (enter_update) begin
            for (int k = 1; k < NUM_TAPS; k++) begin
                z_d[k] = '0;
            end
        end else if (step) begin
            out_d = out_mapped;
            for (int k = 1; k < NUM_TAPS-1; k++) begin
                z_d[k] = prod[k] + z_q[k+1];
            end
            z_d[NUM_TAPS-1] = prod[NUM_TAPS-1];
        end
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q   <= ST_IDLE;
            en_prev_q <= 1'b0;
            out_q     <= '0;
            for (int k = 1; k < NUM_TAPS; k++) begin
                z_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            en_prev_q <= en_prev_d;
            out_q     <= out_d;
            z_q       <= z_d;
        end
    end

    assign oFirOut = out_q;

endmodule

// File: tb/tb_reconf_fir_filter.sv
// Directed-plus-random bench for reconf_fir_filter against a direct-form
// convolution model of the filter (sum of h[k]*x[n-k] over the sample history).
module tb_reconf_fir_filter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        flag;
    logic        csn;
    logic        wrn;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [5:0]  idx;
    logic [2:0]  fir_in;
    logic [15:0] fir_out;

    int checks = 0;
    int errors = 0;

    longint h_m [40];
    longint x_hist [40];
    logic signed [15:0] exp_out;

    int set_a [33] = '{3, 0, -6, 7, 0, -11, 13, 0, -19, 24, 0, -37, 48, 0, -102, 206, 500,
                       206, -102, 0, 48, -37, 0, 24, -19, 0, 13, -11, 0, 7, -6, 0, 3};

    always #5 clk = ~clk;

    reconf_fir_filter dut (
        .iClk_12M          (clk),
        .iRsn              (rst_n),
        .iEnSample_300k    (en),
        .iCoeffiUpdateFlag (flag),
        .iCsnRam           (csn),
        .iWrnRam           (wrn),
        .iAddrRam          (addr),
        .iWrDtRam          (wdata),
        .iNumOfCoeff       (idx),
        .iFirIn            (fir_in),
        .oFirOut           (fir_out)
    );

    function automatic logic signed [15:0] map_out(input longint s);
`ifdef FIR_OUT_SAT_EN
        if (s > 32767) return 16'sd32767;
        if (s < -32768) return -16'sd32768;
        return 16'(s);
`else
        return 16'(s);
`endif
    endfunction

    task automatic model_clear_hist();
        for (int k = 0; k < 40; k++) x_hist[k] = 0;
    endtask

    task automatic model_step(input longint x);
        longint sum;
        for (int k = 39; k > 0; k--) x_hist[k] = x_hist[k-1];
        x_hist[0] = x;
        sum = 0;
        for (int k = 0; k < 40; k++) sum += h_m[k] * x_hist[k];
        exp_out = map_out(sum);
    endtask

    task automatic check(input string tag, input logic signed [15:0] obs,
                         input logic signed [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flag_up(input logic do_wr, input int widx, input int wval);
        flag = 1'b1;
        if (do_wr) begin
            csn = 1'b0; wrn = 1'b0; idx = 6'(widx); wdata = 16'(wval);
        end
        tick();
        if (do_wr && widx < 40) h_m[widx] = longint'($signed(16'(wval)));
        csn = 1'b1; wrn = 1'b1;
        model_clear_hist();
    endtask

    task automatic write_coef(input int widx, input int wval, input logic c, input logic w);
        csn = c; wrn = w; idx = 6'(widx); wdata = 16'(wval); addr = 4'($urandom_range(0, 15));
        tick();
        if (!c && !w && widx < 40) h_m[widx] = longint'($signed(16'(wval)));
        csn = 1'b1; wrn = 1'b1;
    endtask

    task automatic flag_down();
        flag = 1'b0;
        tick();
    endtask

    task automatic strobe(input logic signed [2:0] x, input int width, input string tag);
        fir_in = x;
        en = 1'b1;
        if (width > 1) check({tag, "_pre"}, fir_out, exp_out);
        tick();
        model_step(longint'(x));
        check(tag, fir_out, exp_out);
        for (int i = 1; i < width; i++) begin
            tick();
            check({tag, "_hold"}, fir_out, exp_out);
        end
        en = 1'b0;
        tick();
    endtask

    task automatic ignored_strobe(input string tag);
        fir_in = 3'($urandom_range(0, 7));
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        check(tag, fir_out, exp_out);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; flag = 1'b0; csn = 1'b1; wrn = 1'b1;
        addr = '0; wdata = '0; idx = '0; fir_in = '0;
        for (int k = 0; k < 40; k++) h_m[k] = 0;
        model_clear_hist();
        exp_out = '0;
        repeat (3) tick();
        check("reset_out", fir_out, 16'sd0);
        rst_n = 1'b1;
        tick();
        ignored_strobe("idle_strobe");

        // Load set A; h[0] is written on the same edge the flag rises.
        flag_up(1'b1, 0, set_a[0]);
        for (int k = 1; k < 40; k++) write_coef(k, (k < 33) ? set_a[k] : 0, 1'b0, 1'b0);
        ignored_strobe("update_strobe");
        flag_down();

        strobe(3'sd1, 1, "imp1");
        for (int n = 1; n < 40; n++) strobe(3'sd0, 1, "imp1");
        check("imp1_tail_zero", fir_out, 16'sd0);
        strobe(-3'sd4, 1, "imp_m4");
        for (int n = 1; n < 41; n++) strobe(3'sd0, 1, "imp_m4");
        for (int n = 0; n < 24; n++) strobe(3'($urandom_range(0, 7)), 1, "rand");
        strobe(3'($urandom_range(0, 7)), 2, "wide2");
        strobe(3'($urandom_range(0, 7)), 3, "wide3");

        // Rejected writes plus one valid write to slot 33.
        flag_up(1'b0, 0, 0);
        write_coef(5, $urandom_range(1, 1000), 1'b1, 1'b0);
        write_coef(5, $urandom_range(1, 1000), 1'b0, 1'b1);
        write_coef(42, $urandom_range(1, 1000), 1'b0, 1'b0);
        write_coef(33, 5, 1'b0, 1'b0);
        flag_down();
        strobe(3'sd1, 1, "imp_after_bad_wr");
        for (int n = 1; n < 40; n++) strobe(3'sd0, 1, "imp_after_bad_wr");

        // Large coefficients to exercise saturation or wrap.
        flag_up(1'b0, 0, 0);
        for (int k = 0; k < 40; k++) write_coef(k, 32767, 1'b0, 1'b0);
        flag_down();
        for (int n = 0; n < 42; n++) strobe(3'sd3, 1, "big");
        check("big_final", fir_out, map_out(longint'(40) * 32767 * 3));

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 40; k++) h_m[k] = 0;
        model_clear_hist();
        exp_out = '0;
        check("async_reset_out", fir_out, 16'sd0);
        tick();
        rst_n = 1'b1;
        tick();
        ignored_strobe("post_reset_idle_strobe");
        flag_up(1'b0, 0, 0);
        write_coef(1, 7, 1'b0, 1'b0);
        flag_down();
        strobe(3'sd1, 1, "post_reset_h0_cleared");
        strobe(3'sd0, 1, "post_reset_h1");
        strobe(3'sd0, 1, "post_reset_h2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
